axi_burst_writer: RTL and testbench

Drains the 64-bit capture FIFO on the fabric clock and writes its contents to DRAM as fixed 16-beat AXI3 write bursts into a circular frame buffer. It sits directly downstream of the pixel-clock stream buffer: it consumes that block's first-word-fall-through read port (`dout`, `dout_valid`, `burst_valid`, `dout_ready`) and drives an AXI3 HP write port. It reports frame completion and AXI errors to the control registers.

---
 rtl/axi_burst_writer.sv | 165 ++++++++++++++++
 tb/tb_axi_burst_writer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_writer.sv
// Drains a FWFT capture FIFO into fixed 16-beat AXI3 INCR write bursts over a circular frame buffer.
// Optional build macro AXI_WRITER_SINGLE_FRAME_EN: stop after one frame until the next start.
module axi_burst_writer #(
    parameter int FRAME_BYTES = 307200,
    parameter int ADDR_W      = 32
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [63:0]       fifo_dout,
    input  logic              fifo_valid,
    input  logic              fifo_burst_valid,
    output logic              fifo_rd_en,
    output logic [ADDR_W-1:0] awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [63:0]       wdata,
    output logic [7:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic              frame_done,
    output logic [15:0]       frames_written,
    output logic              busy,
    output logic              error,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a cycle where valid && ready; valid is
    // never a function of ready and, once raised, holds (with its payload)
    // until that transfer.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam int OFF_W = $clog2(FRAME_BYTES + 1);
    localparam logic [OFF_W-1:0] FRAME_END   = OFF_W'(FRAME_BYTES);
    localparam logic [OFF_W-1:0] BURST_BYTES = OFF_W'(128);

    state_t            state_q, state_d;
    logic              running_q, running_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [OFF_W-1:0]  offset_next;
    logic [3:0]        beat_q, beat_d;
    logic              error_q, error_d;
    logic [15:0]       frames_q, frames_d;
    logic              frame_done_q, frame_done_d;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            running_q    <= 1'b0;
            base_q       <= '0;
            offset_q     <= '0;
            beat_q       <= '0;
            error_q      <= 1'b0;
            frames_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            running_q    <= running_d;
            base_q       <= base_d;
            offset_q     <= offset_d;
            beat_q       <= beat_d;
            error_q      <= error_d;
            frames_q     <= frames_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        running_d    = running_q;
        base_d       = base_q;
        offset_d     = offset_q;
        beat_d       = beat_q;
        error_d      = error_q;
        frames_d     = frames_q;
        frame_done_d = 1'b0;
        offset_next  = offset_q + BURST_BYTES;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        wlast        = 1'b0;
        fifo_rd_en   = 1'b0;
        bready       = 1'b0;

        // Arming is only possible while not running, so it never collides
        // with a response being retired below.
        if (start && !running_q) begin
            running_d = 1'b1;
            base_d    = base_addr;
            offset_d  = '0;
            error_d   = 1'b0;
            frames_d  = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (running_q && fifo_burst_valid) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                awvalid = 1'b1;
                beat_d  = '0;
                if (awready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                wvalid     = fifo_valid;
                wlast      = (beat_q == 4'd15);
                fifo_rd_en = fifo_valid && wready;
                if (fifo_rd_en) begin
                    beat_d = beat_q + 4'd1;
                    if (wlast) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    error_d = error_q | (bresp != 2'b00);
                    state_d = S_IDLE;
                    if (offset_next == FRAME_END) begin
                        offset_d     = '0;
                        frame_done_d = 1'b1;
                        frames_d     = frames_q + 16'd1;
`ifdef AXI_WRITER_SINGLE_FRAME_EN
                        running_d    = 1'b0;
`endif
                    end else begin
                        offset_d = offset_next;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign awaddr         = base_q + ADDR_W'(offset_q);
    assign awlen          = 4'd15;
    assign awsize         = 3'd3;
    assign awburst        = 2'b01;
    assign wdata          = fifo_dout;
    assign wstrb          = 8'hFF;
    assign frame_done     = frame_done_q;
    assign frames_written = frames_q;
    assign busy           = running_q;
    assign error          = error_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Self-checking bench for axi_burst_writer: randomized FIFO/AXI slave stimulus
// against a transaction-level reference model, plus directed literal checks.
module tb_axi_burst_writer;
  localparam int FB    = 256;
  localparam int BURST = 128;
  localparam int ST_WAIT = 0, ST_ADDR = 1, ST_DATA = 2, ST_RESP = 3;

  // ---------------- clock / reset ----------------
  logic fclk = 1'b0;
  always #5 fclk = ~fclk;
  logic rst = 1'b1;

  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [63:0] fifo_dout = '0;
  logic        fifo_valid = 1'b0, fifo_burst_valid = 1'b0;
  logic        fifo_rd_en;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready = 1'b0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;
  logic        frame_done;
  logic [15:0] frames_written;
  logic        busy, error;
  logic [1:0]  dbg_state;

  axi_burst_writer #(.FRAME_BYTES(FB), .ADDR_W(32)) dut (
    .fclk(fclk), .rst(rst), .start(start), .base_addr(base_addr),
    .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .fifo_burst_valid(fifo_burst_valid),
    .fifo_rd_en(fifo_rd_en), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .frame_done(frame_done),
    .frames_written(frames_written), .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- stimulus knobs / bench FIFO ----------------
  logic [63:0] fifo_q[$];
  logic [63:0] exp_q[$];
  int  p_aw = 100, p_w = 100, p_b = 100;
  bit  gap_en = 0, hold_bv = 0, feed_en = 0, bresp_rand = 0, restart_en = 0, rand_start = 0;
  int  err_on_burst = -1;

  // observed DUT activity
  logic [31:0] aw_log[$];
  int fd_seen = 0, bursts_seen = 0, w_hs = 0;

  // reference model state
  bit          m_running = 0;
  logic [31:0] m_base = '0;
  int          m_bursts = 0, m_stage = ST_WAIT, m_beats = 0;
  bit          m_err = 0, m_fd = 0;
  logic [15:0] m_frames = '0;

  task automatic push_word();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic preload(input int n);
    @(negedge fclk);
    for (int i = 0; i < n; i++) push_word();
  endtask

  always @(negedge fclk) begin
    if (!rst && feed_en && fifo_q.size() < 48 && $urandom_range(0, 2) != 0) push_word();
  end

  // Slave and FIFO-port driver, updated just after each rising edge.
  always @(posedge fclk) begin
    #1;
    awready = $urandom_range(0, 99) < p_aw;
    wready  = $urandom_range(0, 99) < p_w;
    bvalid  = $urandom_range(0, 99) < p_b;
    if (bursts_seen == err_on_burst) bresp = 2'b10;
    else if (bresp_rand && $urandom_range(0, 7) == 0) bresp = 2'($urandom_range(1, 3));
    else bresp = 2'b00;
    fifo_dout        = (fifo_q.size() > 0) ? fifo_q[0] : 64'd0;
    fifo_valid       = (fifo_q.size() > 0) && !(gap_en && $urandom_range(0, 2) == 0);
    fifo_burst_valid = (fifo_q.size() >= 16) && !hold_bv;
  end

  // ---------------- reference model (transaction level) ----------------
  always @(posedge fclk) begin
    bit was_running;
    if (rst) begin
      fifo_q.delete(); exp_q.delete(); aw_log.delete();
      fd_seen = 0; bursts_seen = 0; w_hs = 0;
      m_running = 0; m_base = '0; m_bursts = 0; m_stage = ST_WAIT;
      m_beats = 0; m_err = 0; m_fd = 0; m_frames = '0;
    end else begin
      if (awvalid && awready) aw_log.push_back(awaddr);
      if (wvalid && wready) w_hs++;
      if (frame_done) fd_seen++;
      if (bvalid && bready) bursts_seen++;
      if (fifo_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());

      m_fd = 0;
      was_running = m_running;
      case (m_stage)
        ST_WAIT: if (was_running && fifo_burst_valid) m_stage = ST_ADDR;
        ST_ADDR: if (awready) begin m_stage = ST_DATA; m_beats = 0; end
        ST_DATA: if (fifo_valid && wready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_beats++;
          if (m_beats == 16) m_stage = ST_RESP;
        end
        default: if (bvalid) begin
          m_err = m_err | (bresp != 2'b00);
          m_bursts++;
          if ((m_bursts * BURST) % FB == 0) begin
            m_frames = m_frames + 16'd1;
            m_fd = 1;
`ifdef AXI_WRITER_SINGLE_FRAME_EN
            m_running = 0;
`endif
          end
          m_stage = ST_WAIT;
        end
      endcase
      if (start && !was_running) begin
        m_running = 1; m_base = base_addr; m_bursts = 0; m_err = 0; m_frames = '0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge fclk) begin
    bit exp_wv;
    logic [31:0] exp_addr;
    if (!rst) begin
      chk("awvalid", awvalid, m_stage == ST_ADDR);
      if (m_stage == ST_ADDR) begin
        exp_addr = m_base + 32'((m_bursts * BURST) % FB);
        chk("awaddr", awaddr, exp_addr);
      end
      exp_wv = (m_stage == ST_DATA) && fifo_valid;
      chk("wvalid", wvalid, exp_wv);
      chk("fifo_rd_en", fifo_rd_en, exp_wv && wready);
      if (exp_wv) begin
        if (exp_q.size() == 0) chk("wdata_avail", 0, 1);
        else chk("wdata", wdata, exp_q[0]);
        chk("wlast", wlast, m_beats == 15);
      end
      chk("bready", bready, m_stage == ST_RESP);
      chk("frame_done", frame_done, m_fd);
      chk("frames_written", frames_written, m_frames);
      chk("busy", busy, m_running);
      chk("error", error, m_err);
      chk("awlen", awlen, 4'd15);
      chk("awsize", awsize, 3'd3);
      chk("awburst", awburst, 2'b01);
      chk("wstrb", wstrb, 8'hFF);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge fclk);
    #2 rst = 1'b1;
    start = 1'b0;
    #1;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_bready", bready, 0);
    chk("rst_fifo_rd_en", fifo_rd_en, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frames", frames_written, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    repeat (2) @(posedge fclk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] b);
    @(posedge fclk); #1;
    start = 1'b1; base_addr = b;
    @(posedge fclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic wait_bursts(input int n, input int budget, input string name);
    int cyc = 0;
    while (bursts_seen < n && cyc < budget) begin
      @(posedge fclk); #1;
      cyc++;
      start = 1'b0;
      if (restart_en && !m_running && cyc % 8 == 0) begin
        start = 1'b1; base_addr = $urandom() & 32'hFFFF_FF80;
      end else if (rand_start && m_running && $urandom_range(0, 30) == 0) begin
        start = 1'b1; base_addr = $urandom() & 32'hFFFF_FF80;
      end
    end
    start = 1'b0;
    checks++;
    if (bursts_seen < n) begin
      errors++;
      $display("FAIL %s timeout bursts=%0d required=%0d", name, bursts_seen, n);
    end
  endtask

  function automatic logic [63:0] aw_at(input int i);
    return (aw_log.size() > i) ? {32'd0, aw_log[i]} : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int guard;
    do_reset();

    // Two bursts from a 32-word preload, all ready lines high.
    preload(32);
    pulse_start(32'h1000_0000);
    wait_bursts(2, 200, "a_bursts");
    wait_cycles(3);
    chk("a_aw_count", aw_log.size(), 2);
    chk("a_addr0", aw_at(0), 64'h1000_0000);
    chk("a_addr1", aw_at(1), 64'h1000_0080);
    chk("a_frame_pulses", fd_seen, 1);
    chk("a_frames", frames_written, 1);
    chk("a_w_hs", w_hs, 32);

    // Fewer than 16 words: nothing may be issued or popped.
    preload(5);
    wait_cycles(40);
    chk("b_no_aw", aw_log.size(), 2);
    chk("b_no_pop", fifo_q.size(), 5);

    // Gapped FIFO and throttled slave.
    do_reset();
    gap_en = 1; p_w = 50; p_aw = 50; p_b = 50;
    preload(16);
    pulse_start(32'h1000_0000);
    wait_bursts(1, 400, "c_burst");
    wait_cycles(2);
    chk("c_w_hs", w_hs, 16);
    chk("c_pops", fifo_q.size(), 0);
    chk("c_addr0", aw_at(0), 64'h1000_0000);

`ifndef AXI_WRITER_SINGLE_FRAME_EN
    // Error response on the second burst; start while running is ignored.
    do_reset();
    gap_en = 0; p_w = 100; p_aw = 100; p_b = 100; feed_en = 1;
    err_on_burst = 1;
    pulse_start(32'h2000_0000);
    wait_bursts(3, 400, "d_bursts");
    err_on_burst = -1;
    chk("d_error_sticky", error, 1);
    chk("d_addr1", aw_at(1), 64'h2000_0080);
    chk("d_addr2", aw_at(2), 64'h2000_0000);
    pulse_start(32'h3000_0000);
    wait_bursts(5, 400, "d_more");
    chk("d_addr4_ignored_start", aw_at(4), 64'h2000_0000);
    chk("d_error_held", error, 1);
    feed_en = 0;
`endif

    // Randomized soak.
    do_reset();
    p_aw = $urandom_range(50, 90); p_w = $urandom_range(50, 90); p_b = $urandom_range(50, 90);
    gap_en = 1; feed_en = 1; bresp_rand = 1; restart_en = 1; rand_start = 1;
    pulse_start($urandom() & 32'hFFFF_FF80);
    wait_bursts(30, 6000, "e_soak");

    // Asynchronous reset in the middle of a data phase.
    guard = 0;
    while (m_stage != ST_DATA && guard < 500) begin wait_cycles(1); guard++; end
    chk("f_reached_data", m_stage == ST_DATA, 1);
    do_reset();
    pulse_start(32'h0800_0000);
    wait_bursts(4, 1000, "f_after_reset");
    restart_en = 0; rand_start = 0; feed_en = 0; bresp_rand = 0;

`ifdef AXI_WRITER_SINGLE_FRAME_EN
    // One frame only, then idle until re-armed at the new base.
    do_reset();
    gap_en = 0; p_aw = 100; p_w = 100; p_b = 100;
    preload(64);
    pulse_start(32'h4000_0000);
    wait_cycles(120);
    chk("g_aw_count", aw_log.size(), 2);
    chk("g_busy", busy, 0);
    chk("g_fifo_left", fifo_q.size(), 32);
    pulse_start(32'h5000_0000);
    wait_bursts(3, 200, "g_rearm");
    chk("g_addr2", aw_at(2), 64'h5000_0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
